// File: rtl/perf_mon_pkg.sv
// Shared definitions for the performance event monitor: FSM state type and default parameter values.
package perf_mon_pkg;

    localparam int DEF_NUM_EVENTS  = 2;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_CYCLE_LIMIT = 30;
    localparam int RD_SEL_W        = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/perf_counter.sv
// Single CNT_W-bit event counter with synchronous clear and sticky overflow flag.
// Build option: PERF_MON_SATURATE_EN holds the count at all-ones on overflow; otherwise it wraps to zero.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_ovf
);

    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_inc) begin
            if (w_at_max) begin
                r_ovf <= 1'b1;
`ifdef PERF_MON_SATURATE_EN
                r_count <= r_count;
`else
                r_count <= '0;
`endif
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/perf_event_monitor.sv
// Performance event monitor: per-channel event counters plus a cycle counter, snapshot shadows and registered readback.
// Build option: PERF_MON_SATURATE_EN selects saturating counters (handled inside perf_counter).
module perf_event_monitor
    import perf_mon_pkg::*;
#(
    parameter int NUM_EVENTS  = DEF_NUM_EVENTS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  snap_i,
    input  logic [RD_SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]      rd_data_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic [NUM_EVENTS:0]   ovf_o,
    output logic [1:0]            dbg_state_o
);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_count_en;
    logic             w_limit_hit;
    logic [64:0]      w_cyc_next;
    logic [NUM_EVENTS:0] w_inc;
    logic [NUM_EVENTS:0] w_ovf;
    logic [CNT_W-1:0] w_live   [0:NUM_EVENTS];
    logic [CNT_W-1:0] r_shadow [0:NUM_EVENTS];
    logic [CNT_W-1:0] r_rd_data;
    logic [CNT_W-1:0] w_rd_mux;

    // Counting happens in IDLE too, so the cycle that starts a run is itself counted.
    assign w_count_en = start_i && (r_state == ST_IDLE || r_state == ST_RUN);
    assign w_inc      = {w_count_en, event_i & {NUM_EVENTS{w_count_en}}};

    // Compare in 65 bits so a limit wider than the counter can never alias.
    assign w_cyc_next  = 65'(w_live[NUM_EVENTS]) + 65'd1;
    assign w_limit_hit = (CYCLE_LIMIT != 0) && (w_cyc_next == 65'(CYCLE_LIMIT));

    genvar g;
    generate
        for (g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
            perf_counter #(.CNT_W(CNT_W)) u_cnt (
                .i_clk   (clk_i),
                .i_rst   (rst_i),
                .i_clear (clear_i),
                .i_inc   (w_inc[g]),
                .o_count (w_live[g]),
                .o_ovf   (w_ovf[g])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clear_i) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start_i) w_next_state = w_limit_hit ? ST_DONE : ST_RUN;
                ST_RUN:  if (start_i && w_limit_hit) w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_DONE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k <= NUM_EVENTS; k++) begin
            if (rd_sel_i == RD_SEL_W'(k)) w_rd_mux = r_shadow[k];
        end
    end

    // Readback samples the shadows before a same-edge snapshot lands.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k <= NUM_EVENTS; k++) r_shadow[k] <= '0;
            r_rd_data <= '0;
        end else if (clear_i) begin
            for (int k = 0; k <= NUM_EVENTS; k++) r_shadow[k] <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_mux;
            if (snap_i) begin
                for (int k = 0; k <= NUM_EVENTS; k++) r_shadow[k] <= w_live[k];
            end
        end
    end

    assign rd_data_o   = r_rd_data;
    assign running_o   = (r_state == ST_RUN);
    assign done_o      = (r_state == ST_DONE);
    assign ovf_o       = w_ovf;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a default instance and an 8-bit unlimited instance share stimulus and a count-based model.
module tb_perf_event_monitor;
    import perf_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, clear, snap;
    logic [1:0] ev;
    logic [4:0] sel;
    logic [31:0] rd_a;
    logic        run_a, done_a;
    logic [2:0]  ovf_a;
    logic [1:0]  st_a;
    logic [7:0]  rd_b;
    logic        run_b, done_b;
    logic [2:0]  ovf_b;
    logic [1:0]  st_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    perf_event_monitor dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
        .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd_a), .running_o(run_a),
        .done_o(done_a), .ovf_o(ovf_a), .dbg_state_o(st_a)
    );

    perf_event_monitor #(.NUM_EVENTS(2), .CNT_W(8), .CYCLE_LIMIT(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .event_i(ev),
        .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd_b), .running_o(run_b),
        .done_o(done_b), .ovf_o(ovf_b), .dbg_state_o(st_b)
    );

    // Reference model: true event totals as plain integers; the visible counter
    // value is derived from the total by wrapping or saturating at the width.
    int     cfg_w   [2] = '{32, 8};
    int     cfg_lim [2] = '{30, 0};
    longint m_cnt [2][3];
    longint m_sh  [2][3];
    longint m_rd  [2];
    bit     m_started [2];

    function automatic longint max_of(int m);
        return (longint'(1) << cfg_w[m]) - 1;
    endfunction

    function automatic longint live(int m, int k);
        if (m_cnt[m][k] <= max_of(m)) return m_cnt[m][k];
`ifdef PERF_MON_SATURATE_EN
        return max_of(m);
`else
        return m_cnt[m][k] % (max_of(m) + 1);
`endif
    endfunction

    function automatic bit m_done(int m);
        return (cfg_lim[m] != 0) && (m_cnt[m][2] == longint'(cfg_lim[m]));
    endfunction

    function automatic bit m_run(int m);
        return m_started[m] && !m_done(m);
    endfunction

    function automatic logic [2:0] exp_ovf(int m);
        logic [2:0] v;
        for (int k = 0; k < 3; k++) v[k] = (m_cnt[m][k] > max_of(m));
        return v;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[m][k] = 0;
                m_sh[m][k]  = 0;
            end
            m_rd[m]      = 0;
            m_started[m] = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int m = 0; m < 2; m++) begin
            if (clear) begin
                for (int k = 0; k < 3; k++) begin
                    m_cnt[m][k] = 0;
                    m_sh[m][k]  = 0;
                end
                m_rd[m]      = 0;
                m_started[m] = 1'b0;
            end else begin
                m_rd[m] = (sel <= 5'd2) ? m_sh[m][sel] : 0;
                if (snap) for (int k = 0; k < 3; k++) m_sh[m][k] = live(m, k);
                if (!m_done(m) && start) begin
                    m_started[m] = 1'b1;
                    m_cnt[m][2]++;
                    for (int k = 0; k < 2; k++) if (ev[k]) m_cnt[m][k]++;
                end
            end
        end
    endfunction

    // Inputs change on the falling edge; the model advances on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        start = 1'b0; clear = 1'b0; snap = 1'b0; ev = 2'b00; sel = 5'd0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (st_a !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st_a, ST_IDLE); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL reset_running: got %0d expected 0", run_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %0d expected 0", done_a); end
        checks++; if (rd_a !== 32'd0) begin errors++; $display("FAIL reset_rd_a: got %0d expected 0", rd_a); end
        checks++; if (ovf_a !== 3'b000) begin errors++; $display("FAIL reset_ovf_a: got %b expected 000", ovf_a); end
        checks++; if (rd_b !== 8'd0) begin errors++; $display("FAIL reset_rd_b: got %0d expected 0", rd_b); end
        rst = 1'b0;
        tick();
        checks++; if (run_a !== 1'b0 || run_b !== 1'b0) begin errors++; $display("FAIL idle_wait: got %0d/%0d expected 0/0", run_a, run_b); end
    endtask

    task automatic test_limit();
        int n;
        n = 0;
        do_clear();
        start = 1'b1; ev = 2'b01;
        while (!done_a && n < 40) begin
            tick();
            n++;
        end
        checks++; if (done_a !== 1'b1 || n != 30) begin errors++; $display("FAIL limit_done: got %0d cycles expected 30", n); end
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL limit_running: got %0d expected 0", run_a); end
        ev = 2'b11;
        repeat (3) tick();
        snap = 1'b1; start = 1'b0; ev = 2'b00;
        tick();
        snap = 1'b0; sel = 5'd0;
        tick();
        checks++; if (rd_a !== 32'd30) begin errors++; $display("FAIL limit_sel0: got %0d expected 30", rd_a); end
        sel = 5'd1;
        tick();
        checks++; if (rd_a !== 32'd0) begin errors++; $display("FAIL limit_sel1: got %0d expected 0", rd_a); end
        sel = 5'd2;
        tick();
        checks++; if (rd_a !== 32'd30) begin errors++; $display("FAIL limit_sel2: got %0d expected 30", rd_a); end
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL limit_hold: got %0d expected 1", done_a); end
    endtask

    task automatic test_pause();
        int n;
        do_clear();
        for (int i = 0; i < 30; i++) begin
            start = !(i >= 10 && i < 13);
            ev = (i == 5 || i == 6 || i == 10 || i == 11) ? 2'b11 : 2'b00;
            tick();
        end
        start = 1'b0; ev = 2'b00; snap = 1'b1;
        tick();
        snap = 1'b0; sel = 5'd2;
        tick();
        checks++; if (rd_a !== 32'd27) begin errors++; $display("FAIL pause_cycles: got %0d expected 27", rd_a); end
        sel = 5'd0;
        tick();
        checks++; if (rd_a !== 32'd2) begin errors++; $display("FAIL pause_ch0: got %0d expected 2", rd_a); end
        sel = 5'd1;
        tick();
        checks++; if (rd_a !== 32'd2) begin errors++; $display("FAIL pause_ch1: got %0d expected 2", rd_a); end
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL pause_running: got %0d expected 1", run_a); end
        start = 1'b1; n = 0;
        while (!done_a && n < 10) begin
            tick();
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL pause_remaining: got %0d expected 3", n); end
        start = 1'b0; snap = 1'b1;
        tick();
        snap = 1'b0; sel = 5'd2;
        tick();
        checks++; if (rd_a !== 32'd30) begin errors++; $display("FAIL pause_total: got %0d expected 30", rd_a); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_v;
`ifdef PERF_MON_SATURATE_EN
        exp_v = 8'd255;
`else
        exp_v = 8'd44;
`endif
        do_clear();
        start = 1'b1; ev = 2'b01;
        repeat (300) tick();
        start = 1'b0; ev = 2'b00;
        checks++; if (ovf_b !== 3'b101) begin errors++; $display("FAIL ovf_b: got %b expected 101", ovf_b); end
        checks++; if (ovf_a !== 3'b000) begin errors++; $display("FAIL ovf_a: got %b expected 000", ovf_a); end
        checks++; if (run_b !== 1'b1 || done_b !== 1'b0) begin errors++; $display("FAIL unlimited_run: got %0d/%0d expected 1/0", run_b, done_b); end
        snap = 1'b1;
        tick();
        snap = 1'b0; sel = 5'd0;
        tick();
        checks++; if (rd_b !== exp_v) begin errors++; $display("FAIL ovf_sel0: got %0d expected %0d", rd_b, exp_v); end
        sel = 5'd2;
        tick();
        checks++; if (rd_b !== exp_v) begin errors++; $display("FAIL ovf_cycles: got %0d expected %0d", rd_b, exp_v); end
    endtask

    task automatic test_clear_snap();
        start = 1'b1; ev = 2'b11;
        repeat (5) tick();
        clear = 1'b1; snap = 1'b1;
        tick();
        clear = 1'b0; snap = 1'b0; start = 1'b0; ev = 2'b00;
        checks++; if (run_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL clr_state: got %0d/%0d expected 0/0", run_a, done_a); end
        checks++; if (ovf_a !== 3'b000 || ovf_b !== 3'b000) begin errors++; $display("FAIL clr_ovf: got %b/%b expected 000/000", ovf_a, ovf_b); end
        for (int s = 0; s < 3; s++) begin
            sel = 5'(s);
            tick();
            checks++; if (rd_a !== 32'd0 || rd_b !== 8'd0) begin errors++; $display("FAIL clr_read%0d: got %0d/%0d expected 0/0", s, rd_a, rd_b); end
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        start = 1'b1; ev = 2'b11;
        repeat (12) tick();
        start = 1'b0; ev = 2'b00; snap = 1'b1;
        tick();
        snap = 1'b0; sel = 5'd0;
        tick();
        checks++; if (rd_a !== 32'd12) begin errors++; $display("FAIL pre_reset_count: got %0d expected 12", rd_a); end
        #2 rst = 1'b1;
        #1;
        checks++; if (run_a !== 1'b0 || run_b !== 1'b0) begin errors++; $display("FAIL async_running: got %0d/%0d expected 0/0", run_a, run_b); end
        checks++; if (rd_a !== 32'd0 || rd_b !== 8'd0) begin errors++; $display("FAIL async_rd: got %0d/%0d expected 0/0", rd_a, rd_b); end
        model_reset();
        #1 rst = 1'b0;
        repeat (3) tick();
        checks++; if (run_a !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %0d expected 0", run_a); end
        snap = 1'b1;
        tick();
        snap = 1'b0; sel = 5'd0;
        tick();
        checks++; if (rd_a !== 32'd0) begin errors++; $display("FAIL post_reset_count: got %0d expected 0", rd_a); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (run_a !== 1'b1) begin errors++; $display("FAIL restart: got %0d expected 1", run_a); end
    endtask

    task automatic test_read_sel();
        do_clear();
        start = 1'b1; ev = 2'b01;
        repeat (5) tick();
        start = 1'b0; ev = 2'b00; snap = 1'b1;
        tick();
        snap = 1'b0; sel = 5'd31;
        tick();
        checks++; if (rd_a !== 32'd0 || rd_b !== 8'd0) begin errors++; $display("FAIL sel31: got %0d/%0d expected 0/0", rd_a, rd_b); end
        sel = 5'd0;
        tick();
        checks++; if (rd_a !== 32'd5) begin errors++; $display("FAIL sel0_first: got %0d expected 5", rd_a); end
        start = 1'b1; ev = 2'b01;
        repeat (3) tick();
        start = 1'b0; ev = 2'b00; snap = 1'b1;
        tick();
        checks++; if (rd_a !== 32'd5) begin errors++; $display("FAIL snap_read_old: got %0d expected 5", rd_a); end
        snap = 1'b0;
        tick();
        checks++; if (rd_a !== 32'd8) begin errors++; $display("FAIL snap_read_new: got %0d expected 8", rd_a); end
    endtask

    task automatic test_random();
        do_clear();
        for (int i = 0; i < 300; i++) begin
            start = ($urandom_range(0, 3) != 0);
            ev    = 2'($urandom_range(0, 3));
            snap  = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 63) == 0);
            sel   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 2));
            tick();
            checks++; if (run_a !== m_run(0) || done_a !== m_done(0)) begin errors++; $display("FAIL rnd_state_a@%0d: got %0d/%0d expected %0d/%0d", i, run_a, done_a, m_run(0), m_done(0)); end
            checks++; if (rd_a !== 32'(m_rd[0])) begin errors++; $display("FAIL rnd_rd_a@%0d: got %0d expected %0d", i, rd_a, m_rd[0]); end
            checks++; if (ovf_a !== exp_ovf(0)) begin errors++; $display("FAIL rnd_ovf_a@%0d: got %b expected %b", i, ovf_a, exp_ovf(0)); end
            checks++; if (run_b !== m_run(1) || done_b !== m_done(1)) begin errors++; $display("FAIL rnd_state_b@%0d: got %0d/%0d expected %0d/%0d", i, run_b, done_b, m_run(1), m_done(1)); end
            checks++; if (rd_b !== 8'(m_rd[1])) begin errors++; $display("FAIL rnd_rd_b@%0d: got %0d expected %0d", i, rd_b, m_rd[1]); end
            checks++; if (ovf_b !== exp_ovf(1)) begin errors++; $display("FAIL rnd_ovf_b@%0d: got %b expected %b", i, ovf_b, exp_ovf(1)); end
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        model_reset();
        test_reset();
        test_limit();
        test_pause();
        test_overflow();
        test_clear_snap();
        test_async_reset();
        test_read_sel();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
